// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data RAM between the CPU MEM stage (port 0) and a
//   debug/loader port (port 1). One RAM access is issued per cycle and read
//   data is returned to the issuing port one cycle later. The CPU is stalled
//   whenever it requests and does not get the RAM.
//
//   Arbitration: a lone requester wins. On contention the CPU wins until the
//   debug port has been denied MAX_WAIT consecutive requesting cycles, after
//   which the debug port wins once.
//
//   Optional build macro MEM_ARB_LOCK_EN: the debug port can hold the RAM
//   with dbg_lock_i once it has been granted. Without the macro dbg_lock_i
//   is ignored.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-low reset
//   cpu_req/we/addr/wdata/wid  CPU request fields (held until granted)
//   cpu_gnt_o, cpu_stall_o     CPU grant this cycle, CPU stall
//   cpu_rvalid_o, cpu_rdata_o  CPU read response
//   dbg_req/we/addr/wdata/wid  debug request fields (held until granted)
//   dbg_lock_i                 debug bus lock (MEM_ARB_LOCK_EN only)
//   dbg_gnt_o                  debug grant this cycle
//   dbg_rvalid_o, dbg_rdata_o  debug read response
//   ram_en/ewr/addr/wdata/wid  RAM request, driven by the granted port
//   ram_rdata_i                RAM read data, valid the cycle after a read

module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned WID_WIDTH  = 3,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic [WID_WIDTH-1:0]  cpu_wid_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_stall_o,
    output logic                  cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,

    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
    input  logic [WID_WIDTH-1:0]  dbg_wid_i,
    input  logic                  dbg_lock_i,
    output logic                  dbg_gnt_o,
    output logic                  dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0] dbg_rdata_o,

    output logic                  ram_en_o,
    output logic                  ram_ewr_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic [WID_WIDTH-1:0]  ram_wid_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;
    logic       resp_valid;
    port_e      resp_port;
    logic       cpu_gnt;
    logic       dbg_gnt;
    logic       locked;

`ifdef MEM_ARB_LOCK_EN
    logic lock_owner;

    // Qualifying with dbg_lock_i releases the lock in the very cycle the
    // debug port drops it, so normal arbitration applies in that cycle.
    assign locked = lock_owner & dbg_lock_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lock_owner <= 1'b0;
        end else if (dbg_gnt && dbg_lock_i) begin
            lock_owner <= 1'b1;
        end else if (!dbg_lock_i) begin
            lock_owner <= 1'b0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = dbg_lock_i;
    assign locked      = 1'b0;
`endif

    // Grant decision: combinational from current requests and registered state.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst_i) begin
            if (locked) begin
                dbg_gnt = dbg_req_i;
            end else if (cpu_req_i && dbg_req_i) begin
                if (wait_cnt >= MAX_WAIT_C) begin
                    dbg_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else begin
                cpu_gnt = cpu_req_i;
                dbg_gnt = dbg_req_i;
            end
        end
    end

    // Issue path: granted port's fields onto the RAM, zero when idle.
    always_comb begin
        ram_en_o    = cpu_gnt | dbg_gnt;
        ram_ewr_o   = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wid_o   = '0;
        if (cpu_gnt) begin
            ram_ewr_o   = cpu_we_i;
            ram_addr_o  = cpu_addr_i;
            ram_wdata_o = cpu_wdata_i;
            ram_wid_o   = cpu_wid_i;
        end else if (dbg_gnt) begin
            ram_ewr_o   = dbg_we_i;
            ram_addr_o  = dbg_addr_i;
            ram_wdata_o = dbg_wdata_i;
            ram_wid_o   = dbg_wid_i;
        end
    end

    // Response path: independent of the issue path.
    always_comb begin
        cpu_rvalid_o = rst_i & resp_valid & (resp_port == PORT_CPU);
        dbg_rvalid_o = rst_i & resp_valid & (resp_port == PORT_DBG);
        cpu_rdata_o  = cpu_rvalid_o ? ram_rdata_i : '0;
        dbg_rdata_o  = dbg_rvalid_o ? ram_rdata_i : '0;
    end

    assign cpu_gnt_o   = cpu_gnt;
    assign dbg_gnt_o   = dbg_gnt;
    assign cpu_stall_o = cpu_req_i & ~cpu_gnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wait_cnt   <= '0;
            resp_valid <= 1'b0;
            resp_port  <= PORT_CPU;
        end else begin
            if (dbg_gnt) begin
                wait_cnt <= '0;
            end else if (dbg_req_i && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            resp_valid <= ram_en_o & ~ram_ewr_o;
            resp_port  <= dbg_gnt ? PORT_DBG : PORT_CPU;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 64;
    localparam int unsigned WW = 3;
    localparam int unsigned MW = 8;
`ifdef MEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [WW-1:0] cpu_wid = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [WW-1:0] dbg_wid = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          ram_en, ram_ewr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [WW-1:0] ram_wid;
    logic [DW-1:0] ram_rdata = '0;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WID_WIDTH(WW), .MAX_WAIT(MW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_wid_i(cpu_wid),
        .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall),
        .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_wid_i(dbg_wid), .dbg_lock_i(dbg_lock),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .ram_en_o(ram_en), .ram_ewr_o(ram_ewr), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_wid_o(ram_wid), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: registered read, one access per cycle.
    bit [DW-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_ewr) ram_mem[ram_addr[7:0]] <= ram_wdata;
            else         ram_rdata <= ram_mem[ram_addr[7:0]];
        end
    end

    // Reference model state.
    int unsigned m_wait;
    bit          m_pend, m_pend_dbg, m_lock;
    logic [DW-1:0] m_pend_data;
    bit [DW-1:0] m_mem [256];
    bit          m_cpu_gnt, m_dbg_gnt;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predicts this cycle's outputs from the rules, optionally compares,
    // then advances the model past the coming clock edge.
    task automatic model_step(input bit do_check);
        bit cg, dg, crv, drv, locked;
        cg = 0; dg = 0; crv = 0; drv = 0;
        if (rst) begin
            locked = LOCK_EN && m_lock && dbg_lock;
            if (locked)                    dg = dbg_req;
            else if (cpu_req && dbg_req)   begin dg = (m_wait >= MW); cg = !dg; end
            else                           begin cg = cpu_req; dg = dbg_req; end
            crv = m_pend && !m_pend_dbg;
            drv = m_pend && m_pend_dbg;
        end
        if (do_check) begin
            chk("cpu_gnt", cpu_gnt, cg);
            chk("dbg_gnt", dbg_gnt, dg);
            chk("ram_en", ram_en, cg | dg);
            chk("cpu_rvalid", cpu_rvalid, crv);
            chk("dbg_rvalid", dbg_rvalid, drv);
            if (rst) chk("cpu_stall", cpu_stall, cpu_req & ~cg);
            if (cg) begin
                chk("ram_ewr", ram_ewr, cpu_we);
                chk("ram_addr", ram_addr, cpu_addr);
                chk("ram_wdata", ram_wdata, cpu_wdata);
                chk("ram_wid", ram_wid, cpu_wid);
            end else if (dg) begin
                chk("ram_ewr", ram_ewr, dbg_we);
                chk("ram_addr", ram_addr, dbg_addr);
                chk("ram_wdata", ram_wdata, dbg_wdata);
                chk("ram_wid", ram_wid, dbg_wid);
            end
            if (!rst) begin
                chk("rst_ram_addr", ram_addr, 0);
                chk("rst_ram_wdata", ram_wdata, 0);
                chk("rst_ram_wid", ram_wid, 0);
                chk("rst_cpu_rdata", cpu_rdata, 0);
                chk("rst_dbg_rdata", dbg_rdata, 0);
            end
            if (crv) begin
                chk("cpu_rdata", cpu_rdata, m_pend_data);
                chk("dbg_rdata_idle", dbg_rdata, 0);
            end
            if (drv) begin
                chk("dbg_rdata", dbg_rdata, m_pend_data);
                chk("cpu_rdata_idle", cpu_rdata, 0);
            end
        end
        if (!rst) begin
            m_wait = 0; m_pend = 0; m_pend_dbg = 0; m_lock = 0;
        end else begin
            if (dg)           m_wait = 0;
            else if (dbg_req) m_wait = (m_wait >= 255) ? 255 : m_wait + 1;
            m_pend = 0;
            if (cg) begin
                if (cpu_we) m_mem[cpu_addr[7:0]] = cpu_wdata;
                else begin m_pend = 1; m_pend_dbg = 0; m_pend_data = m_mem[cpu_addr[7:0]]; end
            end else if (dg) begin
                if (dbg_we) m_mem[dbg_addr[7:0]] = dbg_wdata;
                else begin m_pend = 1; m_pend_dbg = 1; m_pend_data = m_mem[dbg_addr[7:0]]; end
            end
            if (LOCK_EN) begin
                if (dg && dbg_lock) m_lock = 1;
                else if (!dbg_lock) m_lock = 0;
            end
        end
        m_cpu_gnt = cg;
        m_dbg_gnt = dg;
    endtask

    task automatic step(input bit do_check);
        #1;
        model_step(do_check);
        @(negedge clk);
    endtask

    task automatic set_req(input bit cr, input bit cw, input int unsigned ca, input logic [DW-1:0] cd,
                           input bit dr, input bit dw, input int unsigned da);
        cpu_req = cr; cpu_we = cw; cpu_addr = AW'(ca); cpu_wdata = cd; cpu_wid = 3'd3;
        dbg_req = dr; dbg_we = dw; dbg_addr = AW'(da); dbg_wdata = '0; dbg_wid = 3'd5;
    endtask

    typedef struct {
        bit cr; bit cw; int unsigned ca; logic [DW-1:0] cd;
        bit dr; bit dw; int unsigned da;
        bit e_cg; bit e_dg; bit e_crv; bit e_drv; logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
            m_mem[i]   = 64'hA5A5_0000_0000_0000 | 64'(i);
        end
        ram_mem[16] = 64'h0000_0000_DEAD_BEEF;
        m_mem[16]   = 64'h0000_0000_DEAD_BEEF;

        //          cr cw ca    cd     dr dw da   cg dg crv drv rdata
        vecs[0] = '{1, 0, 'h10, 0,     0, 0, 0,   1, 0, 0,  0,  0};
        vecs[1] = '{0, 0, 0,    0,     0, 0, 0,   0, 0, 1,  0,  64'hDEAD_BEEF};
        vecs[2] = '{1, 0, 'h0,  0,     0, 0, 0,   1, 0, 0,  0,  0};
        vecs[3] = '{0, 0, 0,    0,     1, 0, 'h8, 0, 1, 1,  0,  64'hA5A5_0000_0000_0000};
        vecs[4] = '{1, 1, 'h10, 'h55,  0, 0, 0,   1, 0, 0,  1,  64'hA5A5_0000_0000_0008};
        vecs[5] = '{1, 0, 'h10, 0,     0, 0, 0,   1, 0, 0,  0,  0};
        vecs[6] = '{0, 0, 0,    0,     0, 0, 0,   0, 0, 1,  0,  64'h55};

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1);
        rst = 1'b1;

        // Directed table: CPU-only read, then back-to-back mixed traffic.
        for (int i = 0; i < 7; i++) begin
            set_req(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].dr, vecs[i].dw, vecs[i].da);
            #1;
            chk($sformatf("vec%0d_cpu_gnt", i), cpu_gnt, vecs[i].e_cg);
            chk($sformatf("vec%0d_dbg_gnt", i), dbg_gnt, vecs[i].e_dg);
            chk($sformatf("vec%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
            chk($sformatf("vec%0d_dbg_rvalid", i), dbg_rvalid, vecs[i].e_drv);
            if (vecs[i].e_crv) chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rd);
            if (vecs[i].e_drv) chk($sformatf("vec%0d_dbg_rdata", i), dbg_rdata, vecs[i].e_rd);
            model_step(1);
            @(negedge clk);
        end

        // Contention: debug wins every ninth cycle.
        for (int k = 0; k < 20; k++) begin
            set_req(1, 0, 1, 0, 1, 0, 2);
            #1;
            chk("contend_dbg_gnt", dbg_gnt, (k == 8 || k == 17));
            chk("contend_stall", cpu_stall, (k == 8 || k == 17));
            model_step(1);
            @(negedge clk);
        end

        // Reset right after a granted read: response dropped, counter cleared.
        set_req(1, 0, 3, 0, 0, 0, 0);
        step(1);
        set_req(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rstmid_cpu_rvalid", cpu_rvalid, 0);
            chk("rstmid_dbg_rvalid", dbg_rvalid, 0);
            model_step(1);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("rstrel_cpu_rvalid", cpu_rvalid, 0);
        model_step(1);
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            set_req(1, 0, 4, 0, 1, 0, 5);
            #1;
            chk("postrst_dbg_gnt", dbg_gnt, (k == 8));
            model_step(1);
            @(negedge clk);
        end

        // Idle.
        set_req(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("idle_ram_en", ram_en, 0);
            model_step(1);
            @(negedge clk);
        end

`ifdef MEM_ARB_LOCK_EN
        dbg_lock = 1'b1;
        set_req(0, 0, 0, 0, 1, 0, 6);
        #1;
        chk("lock_first_dbg_gnt", dbg_gnt, 1);
        model_step(1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_req(1, 0, 7, 0, 1, 0, 8);
            #1;
            chk("lock_stall", cpu_stall, 1);
            chk("lock_cpu_gnt", cpu_gnt, 0);
            model_step(1);
            @(negedge clk);
        end
        dbg_lock = 1'b0;
        set_req(1, 0, 7, 0, 1, 0, 8);
        #1;
        chk("unlock_cpu_gnt", cpu_gnt, 1);
        model_step(1);
        @(negedge clk);
`endif

        // Randomized traffic with request holding until grant.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (!(cpu_req && !m_cpu_gnt)) begin
                cpu_req   = ($urandom_range(0, 9) < 7);
                cpu_we    = $urandom_range(0, 2) == 0;
                cpu_addr  = AW'($urandom_range(0, 31));
                cpu_wdata = {$urandom, $urandom};
                cpu_wid   = WW'($urandom_range(0, 7));
            end
            if (!(dbg_req && !m_dbg_gnt)) begin
                dbg_req   = ($urandom_range(0, 9) < 6);
                dbg_we    = $urandom_range(0, 2) == 0;
                dbg_addr  = AW'($urandom_range(0, 31));
                dbg_wdata = {$urandom, $urandom};
                dbg_wid   = WW'($urandom_range(0, 7));
            end
            dbg_lock = ($urandom_range(0, 3) == 0);
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
